// File: rtl/dmem_types.sv
// Types and byte-enable constants for the data-memory port.
package dmem_types;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam logic [3:0] MBE_W    = 4'b1111;
   localparam logic [3:0] MBE_H_LO = 4'b0011;
   localparam logic [3:0] MBE_H_HI = 4'b1100;
   localparam logic [3:0] MBE_B    = 4'b0001;
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I encodings used by the memory-stage blocks.
// Load and store funct3 values share numeric codes but are kept as separate types.
package rv32i_types;
   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'd0,
      SH = 3'd1,
      SW = 3'd2
   } store_funct3_t;
endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: byte enables, replicated store data, formatted load data,
// and legality/misalignment flags for one access described by funct3 and addr[1:0].
module dmem_align
   import rv32i_types::*;
   import dmem_types::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_is_store,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_mbe,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_illegal,
   output logic        o_misaligned
);
   logic [15:0] w_shifted;

   assign w_shifted = 16'(i_rdata >> {i_addr_lo, 3'b000});

   // Size lives in funct3[1:0] for both loads and stores.
   always_comb begin
      o_mbe   = '0;
      o_wdata = '0;
      case (i_funct3[1:0])
         2'd0: begin
            o_mbe   = MBE_B << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         2'd1: begin
            o_mbe   = i_addr_lo[1] ? MBE_H_HI : MBE_H_LO;
            o_wdata = {2{i_wdata[15:0]}};
         end
         2'd2: begin
            o_mbe   = MBE_W;
            o_wdata = i_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_rdata = '0;
      case (i_funct3)
         LB:      o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         LH:      o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         LW:      o_rdata = i_rdata;
         LBU:     o_rdata = {24'd0, w_shifted[7:0]};
         LHU:     o_rdata = {16'd0, w_shifted[15:0]};
         default: o_rdata = '0;
      endcase
   end

   assign o_illegal    = i_is_store ? (i_funct3 > SW)
                                    : !(i_funct3 inside {LB, LH, LW, LBU, LHU});
   assign o_misaligned = ((i_funct3[1:0] == 2'd2) && (i_addr_lo != 2'd0)) ||
                         ((i_funct3[1:0] == 2'd1) && i_addr_lo[0]);
endmodule

// File: rtl/dmem_port.sv
// MEM-stage data-memory port: request/response handshake with the D-cache and pipeline stall.
// Build option DMEM_MISALIGN_TRAP_EN turns misaligned word/half accesses into traps.
module dmem_port
   import dmem_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [3:0]        resp_rmask,
   output logic [3:0]        resp_wmask,
   output logic              trap,
   output logic              data_read,
   output logic              data_write,
   output logic [3:0]        data_mbe,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic [DATA_W-1:0] data_rdata,
   input  logic              data_resp
);
   dmem_state_t       r_state;
   logic [2:0]        r_funct3;
   logic [1:0]        r_addr_lo;
   logic              r_is_store;
   logic              r_data_read, r_data_write;
   logic [3:0]        r_data_mbe;
   logic [ADDR_W-1:0] r_data_addr;
   logic [DATA_W-1:0] r_data_wdata;
   logic [DATA_W-1:0] r_resp_rdata;
   logic [3:0]        r_resp_rmask, r_resp_wmask;
   logic              r_trap;

   logic              w_idle, w_accept, w_is_store;
   logic [2:0]        w_funct3;
   logic [1:0]        w_addr_lo;
   logic [3:0]        w_mbe;
   logic [DATA_W-1:0] w_wdata_al, w_rdata_fmt;
   logic              w_illegal, w_misaligned, w_trap_hit, w_bypass;

   // The aligner sees the live request while idle and the latched one afterwards.
   assign w_idle     = (r_state == IDLE);
   assign w_is_store = w_idle ? req_write : r_is_store;
   assign w_funct3   = w_idle ? req_funct3 : r_funct3;
   assign w_addr_lo  = w_idle ? req_addr[1:0] : r_addr_lo;
   assign w_accept   = ~rst & w_idle & req_valid & (req_read | req_write);

   dmem_align u_align (
      .i_funct3     (w_funct3),
      .i_addr_lo    (w_addr_lo),
      .i_is_store   (w_is_store),
      .i_wdata      (req_wdata),
      .i_rdata      (data_rdata),
      .o_mbe        (w_mbe),
      .o_wdata      (w_wdata_al),
      .o_rdata      (w_rdata_fmt),
      .o_illegal    (w_illegal),
      .o_misaligned (w_misaligned)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_trap_hit = ~w_illegal & w_misaligned;
`else
   logic w_unused_misaligned;
   assign w_unused_misaligned = w_misaligned;
   assign w_trap_hit          = 1'b0;
`endif
   assign w_bypass = w_illegal | w_trap_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_funct3     <= '0;
         r_addr_lo    <= '0;
         r_is_store   <= 1'b0;
         r_data_read  <= 1'b0;
         r_data_write <= 1'b0;
         r_data_mbe   <= '0;
         r_data_addr  <= '0;
         r_data_wdata <= '0;
         r_resp_rdata <= '0;
         r_resp_rmask <= '0;
         r_resp_wmask <= '0;
         r_trap       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_funct3   <= req_funct3;
                  r_addr_lo  <= req_addr[1:0];
                  r_is_store <= req_write;
                  if (w_bypass) begin
                     r_state <= DONE;
                     r_trap  <= w_trap_hit;
                  end else begin
                     r_state      <= BUSY;
                     r_data_read  <= ~req_write;
                     r_data_write <= req_write;
                     r_data_mbe   <= w_mbe;
                     r_data_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     r_data_wdata <= req_write ? w_wdata_al : '0;
                  end
               end
            end
            BUSY: begin
               if (data_resp) begin
                  r_state      <= DONE;
                  r_data_read  <= 1'b0;
                  r_data_write <= 1'b0;
                  r_data_mbe   <= '0;
                  r_data_addr  <= '0;
                  r_data_wdata <= '0;
                  r_resp_rdata <= r_is_store ? '0 : w_rdata_fmt;
                  r_resp_rmask <= r_is_store ? 4'd0 : r_data_mbe;
                  r_resp_wmask <= r_is_store ? r_data_mbe : 4'd0;
               end
            end
            DONE: begin
               r_state      <= IDLE;
               r_resp_rdata <= '0;
               r_resp_rmask <= '0;
               r_resp_wmask <= '0;
               r_trap       <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign stall      = ~rst & (w_accept | (r_state == BUSY));
   assign resp_valid = (r_state == DONE);
   assign resp_rdata = r_resp_rdata;
   assign resp_rmask = r_resp_rmask;
   assign resp_wmask = r_resp_wmask;
   assign trap       = r_trap;
   assign data_read  = r_data_read;
   assign data_write = r_data_write;
   assign data_mbe   = r_data_mbe;
   assign data_addr  = r_data_addr;
   assign data_wdata = r_data_wdata;
endmodule

// File: tb/tb_dmem_port.sv
// Randomized and directed bench for dmem_port against a byte-level reference model.
module tb_dmem_port;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_read, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, resp_valid, trap, data_read, data_write, data_resp;
   logic [31:0] resp_rdata, data_addr, data_wdata, data_rdata;
   logic [3:0]  resp_rmask, resp_wmask, data_mbe;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_port #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_rmask(resp_rmask), .resp_wmask(resp_wmask), .trap(trap),
      .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_resp(data_resp)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference: an access covers nb bytes starting at the nb-aligned byte inside the word.
   function automatic void model(input bit is_st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 output bit go_cache, output bit trap_e, output logic [3:0] mbe,
                                 output logic [31:0] wal, output logic [31:0] rdf);
      int nb, off, base;
      bit legal, mis;
      longint v;
      off   = int'(addr[1:0]);
      nb    = 1 << f3[1:0];
      legal = is_st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis   = (off % nb) != 0;
      trap_e   = legal && mis && TRAP_EN;
      go_cache = legal && !trap_e;
      mbe = '0; wal = '0; rdf = '0;
      if (!go_cache) return;
      base = (off / nb) * nb;
      for (int b = 0; b < 4; b++) begin
         if (b >= base && b < base + nb) mbe[b] = 1'b1;
         if (is_st) wal[8*b +: 8] = wd[8*(b % nb) +: 8];
      end
      if (!is_st) begin
         if (nb == 4) rdf = rd;
         else begin
            v = longint'(rd >> (8 * off));
            v = v & ((64'sd1 <<< (8 * nb)) - 1);
            if (!f3[2] && v[8*nb-1]) v = v - (64'sd1 <<< (8 * nb));
            rdf = v[31:0];
         end
      end
   endfunction

   task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdat, input int delay,
                          output logic [3:0] o_mbe, output logic [31:0] o_wdata,
                          output logic [31:0] o_addr, output logic [31:0] o_rdata,
                          output logic [3:0] o_wmask, output int o_stall);
      bit is_st, go, te;
      logic [3:0]  mbe;
      logic [31:0] wal, rdf;
      is_st = wr;
      model(is_st, f3, addr, wd, rdat, go, te, mbe, wal, rdf);
      o_mbe = '0; o_wdata = '0; o_addr = '0;
      @(negedge clk);
      req_valid = 1'b1; req_read = rd; req_write = wr;
      req_funct3 = f3; req_addr = addr; req_wdata = wd;
      #1;
      chk_eq("stall_accept", stall, 1);
      o_stall = int'(stall);
      if (go) begin
         for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            o_stall += int'(stall);
            if (i == 0) begin
               o_mbe = data_mbe; o_wdata = data_wdata; o_addr = data_addr;
            end
            chk_eq("busy_read", data_read, !is_st);
            chk_eq("busy_write", data_write, is_st);
            chk_eq("busy_mbe", data_mbe, mbe);
            chk_eq("busy_addr", data_addr, {addr[31:2], 2'b00});
            chk_eq("busy_wdata", data_wdata, is_st ? wal : 32'h0);
            chk_eq("busy_resp_valid", resp_valid, 0);
            if (i == delay) begin
               data_resp = 1'b1; data_rdata = rdat;
            end
         end
         @(negedge clk);
         data_resp = 1'b0; data_rdata = $urandom;
      end else begin
         @(negedge clk);
      end
      o_rdata = resp_rdata; o_wmask = resp_wmask;
      o_stall += int'(stall);
      chk_eq("done_valid", resp_valid, 1);
      chk_eq("done_read", data_read, 0);
      chk_eq("done_write", data_write, 0);
      chk_eq("done_trap", trap, te);
      chk_eq("done_rdata", resp_rdata, (go && !is_st) ? rdf : 32'h0);
      chk_eq("done_rmask", resp_rmask, (go && !is_st) ? mbe : 4'h0);
      chk_eq("done_wmask", resp_wmask, (go && is_st) ? mbe : 4'h0);
      chk_eq("stall_cycles", o_stall, go ? delay + 2 : 1);
      req_valid = 1'b0;
      @(negedge clk);
      chk_eq("idle_valid", resp_valid, 0);
      chk_eq("idle_stall", stall, 0);
      chk_eq("idle_trap", trap, 0);
      $display("[TB] txn rd=%0d wr=%0d f3=%0d addr=%08h wd=%08h delay=%0d mbe=%h rdata=%08h wmask=%h",
               rd, wr, f3, addr, wd, delay, o_mbe, o_rdata, o_wmask);
   endtask

   logic [3:0]  ob_mbe, ob_wmask;
   logic [31:0] ob_wdata, ob_addr, ob_rdata;
   int          ob_stall;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;
      data_resp = 1'b0; data_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("rst_stall", stall, 0);
      chk_eq("rst_valid", resp_valid, 0);
      chk_eq("rst_trap", trap, 0);
      chk_eq("rst_rd_wr", {data_read, data_write}, 0);
      chk_eq("rst_mbe", data_mbe, 0);
      chk_eq("rst_addr", data_addr, 0);
      chk_eq("rst_wdata", data_wdata, 0);
      chk_eq("rst_rdata", resp_rdata, 0);
      chk_eq("rst_masks", {resp_rmask, resp_wmask}, 0);

      run_txn(0, 1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("sb_mbe", ob_mbe, 4'b1000);
      chk_eq("sb_wdata", ob_wdata, 32'hA5A5_A5A5);
      chk_eq("sb_addr", ob_addr, 32'h0000_1000);
      chk_eq("sb_stall3", ob_stall, 3);
      chk_eq("sb_wmask", ob_wmask, 4'b1000);

      run_txn(1, 0, 3'd0, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lb_rdata", ob_rdata, 32'hFFFF_FF80);
      run_txn(1, 0, 3'd4, 32'h0000_2001, 32'h0, 32'h1234_80FF, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lbu_rdata", ob_rdata, 32'h0000_0080);
      run_txn(1, 0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lh_mbe", ob_mbe, 4'b1100);
      chk_eq("lh_rdata", ob_rdata, 32'hFFFF_8001);
      chk_eq("lh_latency", ob_stall, 2);
      run_txn(1, 0, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_0000, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lhu_rdata", ob_rdata, 32'h0000_8001);
      run_txn(1, 0, 3'd2, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 4,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lw_rdata", ob_rdata, 32'hDEAD_BEEF);
      chk_eq("lw_stall", ob_stall, 6);
      run_txn(1, 0, 3'd2, 32'h0000_4002, 32'h0, 32'h0BAD_F00D, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("lw_mis_mbe", ob_mbe, TRAP_EN ? 4'h0 : 4'hF);
      chk_eq("lw_mis_addr", ob_addr, TRAP_EN ? 32'h0 : 32'h0000_4000);
      run_txn(1, 0, 3'd3, 32'h0000_5000, 32'h0, 32'h1111_1111, 0,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("illegal_ld_mbe", ob_mbe, 4'h0);
      run_txn(1, 1, 3'd2, 32'h0000_6000, 32'hCAFE_0123, 32'h5555_5555, 1,
              ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      chk_eq("rw_store_wmask", ob_wmask, 4'hF);
      chk_eq("rw_store_rdata", ob_rdata, 32'h0);

      // Reset while waiting on the cache; the late response must be dropped.
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
      req_funct3 = 3'd2; req_addr = 32'h0000_7004;
      @(negedge clk);
      req_valid = 1'b0;
      chk_eq("rstbusy_read", data_read, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("rstbusy_rd_wr", {data_read, data_write}, 0);
      chk_eq("rstbusy_stall", stall, 0);
      chk_eq("rstbusy_mbe", data_mbe, 0);
      chk_eq("rstbusy_addr", data_addr, 0);
      data_resp = 1'b1; data_rdata = 32'h7777_7777;
      @(negedge clk);
      data_resp = 1'b0;
      chk_eq("rstbusy_no_resp", resp_valid, 0);
      chk_eq("rstbusy_rdata", resp_rdata, 0);
      @(negedge clk);
      chk_eq("rstbusy_idle", {resp_valid, stall, data_read}, 0);

      for (int n = 0; n < 200; n++) begin
         int k;
         k = $urandom_range(0, 3);
         run_txn(k != 2, k >= 2, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), ob_mbe, ob_wdata, ob_addr, ob_rdata, ob_wmask, ob_stall);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
